// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants for the 5-stage pipeline decode logic:
//                instruction field positions, opcode and ALU-op encodings,
//                and the mult/div tracking FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Instruction field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 17;
    localparam int RT_MSB  = 16;
    localparam int RT_LSB  = 12;
    localparam int ALU_MSB = 6;
    localparam int ALU_LSB = 2;

    // Opcodes
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    // R-type ALU ops handled by the multi-cycle unit
    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    // Mult/div tracking FSM
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/insn_reguse.sv
`default_nettype none
// ============================================================================
//  Module      : insn_reguse
//  Description : Pure combinational decode of one instruction word into its
//                register-usage profile.
//  Ports       : ir         - 32-bit instruction word
//                use_rs     - rs field is read
//                use_rt     - rt field is read (R-type only)
//                use_rd     - rd field is read (bne/blt/jr)
//                writes_rd  - rd field is written (R-type/addi/lw/jal/setx)
//                is_load    - instruction is lw
//                is_muldiv  - R-type mult or div
//  Revision    : 1.0 - initial release
// ============================================================================
module insn_reguse
    import pipe_pkg::*;
(
    input  logic [31:0] ir,
    output logic        use_rs,
    output logic        use_rt,
    output logic        use_rd,
    output logic        writes_rd,
    output logic        is_load,
    output logic        is_muldiv
);

    logic [4:0] w_op;
    logic [4:0] w_alu;
    logic       w_unused_ir;

    assign w_op  = ir[OPC_MSB:OPC_LSB];
    assign w_alu = ir[ALU_MSB:ALU_LSB];
    assign w_unused_ir = &{1'b0, ir[RD_MSB:7], ir[1:0]};

    // sw reads rd too, but that value is bypassed W->M so it is not a
    // decode-stage source.
    assign use_rs    = !(w_op == OP_J || w_op == OP_JAL || w_op == OP_SETX);
    assign use_rt    = (w_op == OP_RTYPE);
    assign use_rd    = (w_op == OP_BNE) || (w_op == OP_BLT) || (w_op == OP_JR);
    assign writes_rd = (w_op == OP_RTYPE) || (w_op == OP_ADDI) || (w_op == OP_LW)
                     || (w_op == OP_JAL) || (w_op == OP_SETX);
    assign is_load   = (w_op == OP_LW);
    assign is_muldiv = (w_op == OP_RTYPE) && (w_alu == ALU_MULT || w_alu == ALU_DIV);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Decode-stage stall unit. Detects load-use hazards and
//                hazards against an in-flight multi-cycle mult/div (RAW, WAW,
//                structural), tracking the mult/div destination in a busy FSM
//                with a watchdog.
//  Ports       : clock, reset (sync, active-high)
//                fd_ir, dx_ir   - instructions in FD and DX latches
//                md_ready       - mult/div result written this cycle
//                flush          - FD/DX squashed by taken branch/jump
//                stall          - freeze PC+FD, bubble into DX
//                stall_reason   - {mult/div, load-use}
//                md_busy, md_rd - FSM busy and tracked destination
//                md_timeout     - sticky watchdog abort flag
//                lu_stall_cycles, md_stall_cycles (HAZARD_PERF_EN only)
//  Config      : define HAZARD_PERF_EN to add saturating stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int MD_TIMEOUT   = 64,
    parameter int PERF_W       = 32,
    parameter int R0_HARDWIRED = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       fd_ir,
    input  logic [31:0]       dx_ir,
    input  logic              md_ready,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        stall_reason,
    output logic              md_busy,
    output logic [4:0]        md_rd,
    output logic              md_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] lu_stall_cycles,
    output logic [PERF_W-1:0] md_stall_cycles
`endif
);

    localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    // Register index match with optional $r0 exemption
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && !((R0_HARDWIRED != 0) && (a == 5'd0));
    endfunction

    md_state_t        r_state;
    logic [4:0]       r_md_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    logic w_fd_use_rs, w_fd_use_rt, w_fd_use_rd, w_fd_wr, w_fd_load, w_fd_md;
    logic w_dx_load, w_dx_md;
    logic w_unused_dx_rs, w_unused_dx_rt, w_unused_dx_rd, w_unused_dx_wr;
    logic w_unused_bits;

    logic [4:0] w_fd_rd, w_fd_rs, w_fd_rt, w_dx_rd, w_tgt;
    logic       w_lu, w_issue, w_md_active, w_md_hz, w_lu_q, w_md_q;

    insn_reguse u_fd_use (
        .ir        (fd_ir),
        .use_rs    (w_fd_use_rs),
        .use_rt    (w_fd_use_rt),
        .use_rd    (w_fd_use_rd),
        .writes_rd (w_fd_wr),
        .is_load   (w_fd_load),
        .is_muldiv (w_fd_md)
    );

    insn_reguse u_dx_use (
        .ir        (dx_ir),
        .use_rs    (w_unused_dx_rs),
        .use_rt    (w_unused_dx_rt),
        .use_rd    (w_unused_dx_rd),
        .writes_rd (w_unused_dx_wr),
        .is_load   (w_dx_load),
        .is_muldiv (w_dx_md)
    );

    assign w_unused_bits = &{1'b0, w_fd_load, fd_ir[OPC_MSB:OPC_LSB], fd_ir[11:0],
                             dx_ir[OPC_MSB:OPC_LSB], dx_ir[RS_MSB:0],
                             w_unused_dx_rs, w_unused_dx_rt, w_unused_dx_rd,
                             w_unused_dx_wr};

    assign w_fd_rd = fd_ir[RD_MSB:RD_LSB];
    assign w_fd_rs = fd_ir[RS_MSB:RS_LSB];
    assign w_fd_rt = fd_ir[RT_MSB:RT_LSB];
    assign w_dx_rd = dx_ir[RD_MSB:RD_LSB];

    // Load-use: lw in DX whose destination is read by FD
    assign w_lu = w_dx_load && (w_dx_rd != 5'd0)
               && ((w_fd_use_rs && reg_hit(w_fd_rs, w_dx_rd))
                || (w_fd_use_rt && reg_hit(w_fd_rt, w_dx_rd))
                || (w_fd_use_rd && reg_hit(w_fd_rd, w_dx_rd)));

    assign w_issue     = w_dx_md && (r_state == MD_IDLE);
    assign w_md_active = w_issue || ((r_state == MD_BUSY) && !md_ready);

    // During the issue cycle the destination is not captured yet, so the
    // comparison target comes straight from DX.
    assign w_tgt = w_issue ? w_dx_rd : r_md_rd;

    assign w_md_hz = w_md_active
                  && ((w_fd_use_rs && reg_hit(w_fd_rs, w_tgt))
                   || (w_fd_use_rt && reg_hit(w_fd_rt, w_tgt))
                   || (w_fd_use_rd && reg_hit(w_fd_rd, w_tgt))
                   || (w_fd_wr     && reg_hit(w_fd_rd, w_tgt))
                   || w_fd_md);

    assign w_lu_q = w_lu    && !flush;
    assign w_md_q = w_md_hz && !flush;

    assign stall        = w_lu_q || w_md_q;
    assign stall_reason = {w_md_q, w_lu_q};
    assign md_busy      = (r_state == MD_BUSY);
    assign md_rd        = r_md_rd;
    assign md_timeout   = r_timeout;

    // Flush never touches the FSM: an issued mult/div always runs to the end.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= MD_IDLE;
            r_md_rd   <= 5'd0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    // A same-cycle md_ready means a 1-cycle op: nothing to track
                    if (w_issue && !md_ready) begin
                        r_state <= MD_BUSY;
                        r_md_rd <= w_dx_rd;
                        r_cnt   <= '0;
                    end
                end
                MD_BUSY: begin
                    if (md_ready) begin
                        r_state <= MD_IDLE;
                        r_md_rd <= 5'd0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_state   <= MD_IDLE;
                        r_md_rd   <= 5'd0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_md_rd <= 5'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_lu_cnt;
    logic [PERF_W-1:0] r_md_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lu_cnt <= '0;
            r_md_cnt <= '0;
        end else begin
            if (w_lu_q && !(&r_lu_cnt)) r_lu_cnt <= r_lu_cnt + 1'b1;
            if (w_md_q && !(&r_md_cnt)) r_md_cnt <= r_md_cnt + 1'b1;
        end
    end

    assign lu_stall_cycles = r_lu_cnt;
    assign md_stall_cycles = r_md_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Directed scoreboard bench for hazard_scoreboard. Stimulus
//                pushes the hand-computed expected outputs into a queue; a
//                monitor pops and compares on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       stall;
        logic [1:0] reason;
        logic       busy;
        logic [4:0] rd;
        logic       tmo;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_ir = 32'd0;
    logic [31:0] dx_ir = 32'd0;
    logic        md_ready = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic [1:0]  stall_reason;
    logic        md_busy;
    logic [4:0]  md_rd;
    logic        md_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] lu_stall_cycles;
    logic [31:0] md_stall_cycles;
`endif

    int    checks = 0;
    int    errors = 0;
    logic  chk_en = 1'b0;
    string chk_name = "";
    exp_t  exp_q[$];

    always #5 clock = ~clock;

    hazard_scoreboard #(
        .MD_TIMEOUT   (64),
        .PERF_W       (32),
        .R0_HARDWIRED (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .md_ready     (md_ready),
        .flush        (flush),
        .stall        (stall),
        .stall_reason (stall_reason),
        .md_busy      (md_busy),
        .md_rd        (md_rd),
        .md_timeout   (md_timeout)
`ifdef HAZARD_PERF_EN
        ,
        .lu_stall_cycles (lu_stall_cycles),
        .md_stall_cycles (md_stall_cycles)
`endif
    );

    // Encoders
    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction
    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs);
        return {op, rd, rs, 17'd0};
    endfunction

    function automatic exp_t mk(input logic s, input logic [1:0] r, input logic b,
                                input logic [4:0] d, input logic t);
        exp_t e;
        e.stall = s; e.reason = r; e.busy = b; e.rd = d; e.tmo = t;
        return e;
    endfunction

    localparam logic [31:0] NOP = 32'd0;

    // Monitor: compares whatever the DUT presents against the queue head
    always @(negedge clock) begin
        if (chk_en) begin
            exp_t e, a;
            a = {stall, stall_reason, md_busy, md_rd, md_timeout};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s: no expected entry queued", chk_name);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got stall=%b reason=%b busy=%b rd=%0d tmo=%b, want stall=%b reason=%b busy=%b rd=%0d tmo=%b",
                             chk_name, a.stall, a.reason, a.busy, a.rd, a.tmo,
                             e.stall, e.reason, e.busy, e.rd, e.tmo);
                end
            end
        end
    end

    // Apply one cycle of inputs and queue the expected outputs for it
    task automatic step(input string nm, input logic [31:0] fd, input logic [31:0] dx,
                        input logic rdy, input logic fl, input exp_t e);
        @(posedge clock); #1;
        fd_ir = fd; dx_ir = dx; md_ready = rdy; flush = fl; reset = 1'b0;
        chk_name = nm;
        exp_q.push_back(e);
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lw5, add_6_5_1, mul8, add_9_8_1;
        lw5       = itype(5'b01000, 5'd5, 5'd2);
        add_6_5_1 = rtype(5'd6, 5'd5, 5'd1, 5'd0);
        mul8      = rtype(5'd8, 5'd2, 5'd3, 5'b00110);
        add_9_8_1 = rtype(5'd9, 5'd8, 5'd1, 5'd0);

        reset = 1'b1;
        repeat (2) @(posedge clock);

        step("reset_state", NOP, NOP, 0, 0, mk(0, 2'b00, 0, 0, 0));
        step("lu_add",      add_6_5_1, lw5, 0, 0, mk(1, 2'b01, 0, 0, 0));
        step("lu_clear",    add_6_5_1, NOP, 0, 0, mk(0, 2'b00, 0, 0, 0));
        step("lu_sw_data",  itype(5'b00111, 5'd5, 5'd3), lw5, 0, 0, mk(0, 2'b00, 0, 0, 0));
        step("lu_sw_base",  itype(5'b00111, 5'd7, 5'd5), lw5, 0, 0, mk(1, 2'b01, 0, 0, 0));

        // Mult/div RAW from issue through completion
        step("md_issue_raw", add_9_8_1, mul8, 0, 0, mk(1, 2'b10, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            step("md_busy_raw", add_9_8_1, NOP, 0, 0, mk(1, 2'b10, 1, 8, 0));
        step("md_ready",    add_9_8_1, NOP, 1, 0, mk(0, 2'b00, 1, 8, 0));
        step("md_idle",     add_9_8_1, NOP, 0, 0, mk(0, 2'b00, 0, 0, 0));

        // Independent, structural, WAW, flush, combined
        step("md_issue_ind", rtype(5'd9, 5'd1, 5'd2, 5'd0), mul8, 0, 0, mk(0, 2'b00, 0, 0, 0));
        step("md_ind",      rtype(5'd9, 5'd1, 5'd2, 5'd0), NOP, 0, 0, mk(0, 2'b00, 1, 8, 0));
        step("md_struct",   rtype(5'd4, 5'd1, 5'd2, 5'b00111), NOP, 0, 0, mk(1, 2'b10, 1, 8, 0));
        step("md_waw",      itype(5'b00101, 5'd8, 5'd0), NOP, 0, 0, mk(1, 2'b10, 1, 8, 0));
        step("md_flush",    add_9_8_1, NOP, 0, 1, mk(0, 2'b00, 1, 8, 0));
        step("both",        rtype(5'd6, 5'd5, 5'd8, 5'd0), lw5, 0, 0, mk(1, 2'b11, 1, 8, 0));
        step("md_done",     NOP, NOP, 1, 0, mk(0, 2'b00, 1, 8, 0));
        step("r0_lw",       rtype(5'd1, 5'd0, 5'd0, 5'd0), itype(5'b01000, 5'd0, 5'd2), 0, 0,
             mk(0, 2'b00, 0, 0, 0));

        // Single-cycle op: issue with md_ready, no capture
        step("md_1cyc",     add_9_8_1, mul8, 1, 0, mk(1, 2'b10, 0, 0, 0));
        step("md_1cyc_after", add_9_8_1, NOP, 0, 0, mk(0, 2'b00, 0, 0, 0));

        // Watchdog: exactly 64 BUSY cycles
        step("to_issue",    NOP, mul8, 0, 0, mk(0, 2'b00, 0, 0, 0));
        for (int i = 0; i < 64; i++)
            step("to_busy",  NOP, NOP, 0, 0, mk(0, 2'b00, 1, 8, 0));
        step("to_expired",  NOP, NOP, 0, 0, mk(0, 2'b00, 0, 0, 1));
        step("to_sticky",   NOP, NOP, 1, 0, mk(0, 2'b00, 0, 0, 1));

        // Reset clears the sticky flag (outputs during the reset cycle are
        // not checked)
        @(posedge clock); #1;
        chk_en = 1'b0;
        reset = 1'b1;
        step("to_reset",    NOP, NOP, 0, 0, mk(0, 2'b00, 0, 0, 0));

        @(posedge clock); #1;
        chk_en = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
